id_ex_stage: RTL

//  ID/EX pipeline register and EX operand network directly upstream of the ALU.

---
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_stage.sv | 57 +++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side fields, bypass sources and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data;
    logic [15:0]       id_imm16;
    logic              id_sign_ext, id_alu_src;
    logic [OP_W-1:0]   id_alu_op;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic              flush;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_result;
    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a, ex_b, ex_store_data;
    logic [OP_W-1:0]   ex_alu_op;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm16,
               id_sign_ext, id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        input  stall, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_op, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm16,
               id_sign_ext, id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               flush, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        output stall, ex_valid, ex_a, ex_b, ex_store_data, ex_alu_op, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB capture bypass, EX operand forwarding
// and load-use stall/bubble insertion.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic              valid, alu_src, reg_write, mem_read, mem_write;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    logic [OP_W-1:0]   alu_op;
    logic              mem_ok, wb_ok, hazard, kill;
    logic [DATA_W-1:0] fwd_rs, fwd_rt, cap_rs, cap_rt, ext;

    always_comb begin
        mem_ok = bus.mem_reg_write && bus.mem_rd != '0;
        wb_ok  = bus.wb_reg_write && bus.wb_rd != '0;
        fwd_rs = (mem_ok && bus.mem_rd == rs) ? bus.mem_result : (wb_ok && bus.wb_rd == rs) ? bus.wb_result : rs_val;
        fwd_rt = (mem_ok && bus.mem_rd == rt) ? bus.mem_result : (wb_ok && bus.wb_rd == rt) ? bus.wb_result : rt_val;
        cap_rs = (wb_ok && bus.wb_rd == bus.id_rs) ? bus.wb_result : bus.id_rs_data;
        cap_rt = (wb_ok && bus.wb_rd == bus.id_rt) ? bus.wb_result : bus.id_rt_data;
        ext    = {{(DATA_W-16){bus.id_sign_ext & bus.id_imm16[15]}}, bus.id_imm16};
        hazard = valid && mem_read && rd != '0 && bus.id_valid && (rd == bus.id_rs || rd == bus.id_rt);
        // An invalid ID slot is captured as a bubble, same as flush/hazard
        kill   = !rst_n || bus.flush || hazard || !bus.id_valid;
    end

    always_ff @(posedge clk) begin
        valid     <= !kill;
        rs        <= kill ? '0 : bus.id_rs;
        rt        <= kill ? '0 : bus.id_rt;
        rd        <= kill ? '0 : bus.id_rd;
        rs_val    <= kill ? '0 : cap_rs;
        rt_val    <= kill ? '0 : cap_rt;
        imm_ext   <= kill ? '0 : ext;
        alu_src   <= !kill && bus.id_alu_src;
        alu_op    <= kill ? '0 : bus.id_alu_op;
        reg_write <= !kill && bus.id_reg_write;
        mem_read  <= !kill && bus.id_mem_read;
        mem_write <= !kill && bus.id_mem_write;
    end

    assign bus.stall         = hazard && !bus.flush;
    assign bus.ex_valid      = valid;
    assign bus.ex_a          = fwd_rs;
    assign bus.ex_b          = alu_src ? imm_ext : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_alu_op     = alu_op;
    assign bus.ex_rd         = rd;
    assign bus.ex_reg_write  = reg_write;
    assign bus.ex_mem_read   = mem_read;
    assign bus.ex_mem_write  = mem_write;
endmodule
